// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK HLS datapath power-estimation slice.
package qpsk_pkg;

  // Output width of the 15x15 unsigned squaring multiplier.
  localparam int unsigned PROD_W = 30;

  // Accumulator width that cannot overflow over 2**log2_win products.
  function automatic int unsigned acc_width(input int unsigned prod_w,
                                            input int unsigned log2_win);
    return prod_w + log2_win;
  endfunction

  // Output register occupancy.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/qpsk_power_accum.sv
// Windowed mean of the squared-sample stream, presented through a
// valid/ready output register with sticky overrun reporting.
module qpsk_power_accum #(
  parameter int unsigned PROD_W   = qpsk_pkg::PROD_W,
  parameter int unsigned LOG2_WIN = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ce,
  input  logic                clear,
  input  logic [PROD_W-1:0]   prod_in,
  input  logic                prod_vld,
  output logic [PROD_W-1:0]   pwr_out,
  output logic                pwr_vld,
  input  logic                pwr_rdy,
  output logic                overrun,
  output logic [LOG2_WIN-1:0] win_cnt
);

  import qpsk_pkg::*;

  localparam int unsigned ACC_W = acc_width(PROD_W, LOG2_WIN);

  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_next;
  logic [ACC_W-1:0]    sum;
  logic [LOG2_WIN-1:0] win_cnt_next;
  logic [PROD_W-1:0]   result;
  logic                accept;
  logic                restart;
  logic                complete;

  out_state_t          out_state;
  out_state_t          out_state_next;
  logic [PROD_W-1:0]   pwr_out_next;
  logic                overrun_next;

  // Sample qualification; clear suppresses a sample on the same edge.
  assign restart  = ce & clear;
  assign accept   = ce & prod_vld & ~clear;
  assign complete = accept & (win_cnt == {LOG2_WIN{1'b1}});
  assign sum      = acc + ACC_W'(prod_in);
  assign result   = PROD_W'(sum >> LOG2_WIN);

  // Next accumulator and window count.
  always_comb begin
    acc_next     = acc;
    win_cnt_next = win_cnt;
    if (restart) begin
      acc_next     = '0;
      win_cnt_next = '0;
    end else if (accept) begin
      acc_next     = complete ? '0 : sum;
      win_cnt_next = win_cnt + LOG2_WIN'(1);
    end
  end

  // Accumulator and window counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      win_cnt <= '0;
    end else begin
      acc     <= acc_next;
      win_cnt <= win_cnt_next;
    end
  end

  // Output register next state: load, consume, or drop into overrun.
  always_comb begin
    out_state_next = out_state;
    pwr_out_next   = pwr_out;
    overrun_next   = overrun;
    case (out_state)
      OUT_EMPTY: begin
        if (complete) begin
          pwr_out_next   = result;
          out_state_next = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (complete) begin
          if (pwr_rdy) begin
            pwr_out_next = result;
          end else begin
            overrun_next = 1'b1;
          end
        end else if (pwr_rdy) begin
          out_state_next = OUT_EMPTY;
        end
      end
      default: out_state_next = OUT_EMPTY;
    endcase
    if (restart) begin
      overrun_next = 1'b0;
    end
  end

  // Output register state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_state <= OUT_EMPTY;
      pwr_out   <= '0;
      overrun   <= 1'b0;
    end else begin
      out_state <= out_state_next;
      pwr_out   <= pwr_out_next;
      overrun   <= overrun_next;
    end
  end

  assign pwr_vld = (out_state == OUT_FULL);

endmodule

// File: tb/tb_qpsk_power_accum.sv
// Directed bench for qpsk_power_accum with a 4-sample window.
module tb_qpsk_power_accum;

  localparam int unsigned PROD_W   = 30;
  localparam int unsigned LOG2_WIN = 2;

  logic                clk;
  logic                reset;
  logic                ce;
  logic                clear;
  logic [PROD_W-1:0]   prod_in;
  logic                prod_vld;
  logic [PROD_W-1:0]   pwr_out;
  logic                pwr_vld;
  logic                pwr_rdy;
  logic                overrun;
  logic [LOG2_WIN-1:0] win_cnt;

  int n_pass;
  int n_total;

  qpsk_power_accum #(
    .PROD_W  (PROD_W),
    .LOG2_WIN(LOG2_WIN)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ce      (ce),
    .clear   (clear),
    .prod_in (prod_in),
    .prod_vld(prod_vld),
    .pwr_out (pwr_out),
    .pwr_vld (pwr_vld),
    .pwr_rdy (pwr_rdy),
    .overrun (overrun),
    .win_cnt (win_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [PROD_W-1:0] v);
    ce       = 1'b1;
    clear    = 1'b0;
    prod_vld = 1'b1;
    prod_in  = v;
    tick();
  endtask

  task automatic idle();
    prod_vld = 1'b0;
    clear    = 1'b0;
    tick();
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    reset    = 1'b1;
    ce       = 1'b1;
    clear    = 1'b0;
    prod_in  = '0;
    prod_vld = 1'b0;
    pwr_rdy  = 1'b1;
    tick();
    tick();
    chk("rst_vld", 64'(pwr_vld), 64'd0);
    chk("rst_out", 64'(pwr_out), 64'd0);
    chk("rst_ovr", 64'(overrun), 64'd0);
    chk("rst_cnt", 64'(win_cnt), 64'd0);
    reset = 1'b0;
    tick();

    // Basic window: 100,200,300,400 -> 250
    sample(30'd100);
    sample(30'd200);
    chk("t1_cnt2", 64'(win_cnt), 64'd2);
    sample(30'd300);
    chk("t1_vld_pre", 64'(pwr_vld), 64'd0);
    sample(30'd400);
    chk("t1_vld", 64'(pwr_vld), 64'd1);
    chk("t1_out", 64'(pwr_out), 64'd250);
    chk("t1_ovr", 64'(overrun), 64'd0);
    chk("t1_cnt0", 64'(win_cnt), 64'd0);
    idle();
    chk("t1_pulse", 64'(pwr_vld), 64'd0);
    chk("t1_hold", 64'(pwr_out), 64'd250);

    // Full-scale products: accumulator must not wrap
    for (int i = 0; i < 4; i++) sample(30'h3FFF_FFFF);
    chk("t2_vld", 64'(pwr_vld), 64'd1);
    chk("t2_out", 64'(pwr_out), 64'h3FFF_FFFF);
    idle();

    // Back-pressure: second window dropped, overrun sticks
    pwr_rdy = 1'b0;
    for (int i = 0; i < 4; i++) sample(30'd8);
    chk("t3_out_a", 64'(pwr_out), 64'd8);
    chk("t3_ovr_a", 64'(overrun), 64'd0);
    for (int i = 0; i < 4; i++) sample(30'd8);
    chk("t3_ovr_b", 64'(overrun), 64'd1);
    chk("t3_vld_b", 64'(pwr_vld), 64'd1);
    for (int i = 0; i < 8; i++) sample(30'd4);
    chk("t3_out_c", 64'(pwr_out), 64'd8);
    chk("t3_ovr_c", 64'(overrun), 64'd1);
    pwr_rdy = 1'b1;
    idle();
    chk("t3_drain", 64'(pwr_vld), 64'd0);
    chk("t3_hold", 64'(pwr_out), 64'd8);

    // ce toggling: only ce-qualified samples count (1,2,3,6 -> 3)
    sample(30'd1);
    ce = 1'b0; prod_in = 30'd99; tick();
    chk("t4_cnt_hold", 64'(win_cnt), 64'd1);
    sample(30'd2);
    ce = 1'b0; prod_in = 30'd99; tick();
    sample(30'd3);
    ce = 1'b0; prod_in = 30'd99; tick();
    chk("t4_vld_pre", 64'(pwr_vld), 64'd0);
    sample(30'd6);
    chk("t4_vld", 64'(pwr_vld), 64'd1);
    chk("t4_out", 64'(pwr_out), 64'd3);
    ce = 1'b0;
    idle();
    chk("t4_drain_noce", 64'(pwr_vld), 64'd0);

    // Build an overrun, then clear with a concurrent sample
    pwr_rdy = 1'b0;
    for (int i = 0; i < 8; i++) sample(30'd16);
    chk("t5_ovr_set", 64'(overrun), 64'd1);
    pwr_rdy = 1'b1;
    idle();
    sample(30'd5);
    sample(30'd5);
    clear = 1'b1; prod_vld = 1'b1; prod_in = 30'd1000; ce = 1'b1; tick();
    chk("t5_clr_cnt", 64'(win_cnt), 64'd0);
    chk("t5_clr_ovr", 64'(overrun), 64'd0);
    chk("t5_clr_vld", 64'(pwr_vld), 64'd0);
    for (int i = 0; i < 4; i++) sample(30'd40);
    chk("t5_out", 64'(pwr_out), 64'd40);
    chk("t5_vld", 64'(pwr_vld), 64'd1);
    idle();

    // Clear on the would-be completing edge wins
    for (int i = 0; i < 3; i++) sample(30'd20);
    clear = 1'b1; prod_vld = 1'b1; prod_in = 30'd20; tick();
    chk("t5b_no_res", 64'(pwr_vld), 64'd0);
    chk("t5b_cnt", 64'(win_cnt), 64'd0);

    // Asynchronous reset mid-window
    for (int i = 0; i < 3; i++) sample(30'd7);
    prod_vld = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_out", 64'(pwr_out), 64'd0);
    chk("t6_rst_vld", 64'(pwr_vld), 64'd0);
    chk("t6_rst_cnt", 64'(win_cnt), 64'd0);
    chk("t6_rst_ovr", 64'(overrun), 64'd0);
    #1;
    reset = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) sample(30'd12);
    chk("t6_out", 64'(pwr_out), 64'd12);
    chk("t6_vld", 64'(pwr_vld), 64'd1);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/qpsk_power_accum.md
Name: qpsk_power_accum

Overview:
Downstream consumer of the 15x15 unsigned, 30-bit, 4-cycle squaring multiplier in the QPSK HLS datapath. It accumulates the squared-sample product stream over a fixed power-of-two window. It emits the window mean as a power estimate for AGC/threshold logic, through a valid/ready output register with sticky overrun reporting.

Parameters:
PROD_W, 30, width of the product input (matches the multiplier output)
LOG2_WIN, 6, log2 of the window length; window = 2**LOG2_WIN samples; legal range 1..16

Ports:
clk        in   1        system clock, all logic on the rising edge
reset      in   1        asynchronous, active-high reset
ce         in   1        clock enable for the input/accumulate side
clear      in   1        synchronous window restart
prod_in    in   PROD_W   unsigned product; already aligned with prod_vld by the upstream 4-stage valid delay
prod_vld   in   1        product valid
pwr_out    out  PROD_W   window mean, unsigned
pwr_vld    out  1        pwr_out holds an unconsumed result
pwr_rdy    in   1        consumer accepts pwr_out
overrun    out  1        sticky: at least one window result was dropped
win_cnt    out  LOG2_WIN samples accepted in the current window

Behaviour:
- Interface fixed: one clock, clk. reset is asynchronous and active-high.
- Reset values: accumulator 0, win_cnt 0, pwr_out 0, pwr_vld 0, overrun 0. Asserting reset mid-window discards the partial sum, with no output.
- Accumulator width ACC_W = PROD_W + LOG2_WIN, so the sum cannot overflow.
- Sample acceptance: a sample is accepted on an edge where ce=1, prod_vld=1 and clear=0.
  - acc <= acc + prod_in
  - win_cnt <= win_cnt + 1, wrapping modulo 2**LOG2_WIN
- ce=0: accumulator, win_cnt and clear handling hold. prod_vld is ignored.
- Output handshake is independent of ce.
- Window completion: an accepted sample with win_cnt == 2**LOG2_WIN-1. On that edge:
  - result = (acc + prod_in) >> LOG2_WIN, truncating floor division
  - acc <= 0
  - win_cnt <= 0
  - Latency: the last sample's edge is edge t; pwr_vld=1 and pwr_out=result are visible after edge t.
- Output register states:
  - EMPTY (pwr_vld=0): completion loads the result. Go to FULL.
  - FULL (pwr_vld=1), pwr_rdy=1, no completion on this edge: go to EMPTY. pwr_out holds its last value.
  - FULL, pwr_rdy=1, completion on the same edge: load the new result and stay FULL. This is not an overrun.
  - FULL, pwr_rdy=0, completion: the new result is dropped and pwr_out is unchanged. overrun <= 1.
- clear (qualified by ce=1):
  - acc <= 0, win_cnt <= 0
  - A sample presented on the same edge is discarded.
  - overrun <= 0.
  - pwr_out/pwr_vld are unaffected.
- Simultaneous clear and completion: clear wins; no result is produced.
- pwr_out is a registered output with no combinational path from any input.
- pwr_vld does not drop without pwr_rdy (AXI-stream-style stability).

Decomposition:
- Shared package qpsk_pkg holds:
  - PROD_W = 30
  - function acc_width(prod_w, log2_win) returning prod_w + log2_win
  - the output state enum {OUT_EMPTY, OUT_FULL}
- No sub-module: the accumulator, window counter and output register together fit in one module of about 150 lines.

Test Plan:
- LOG2_WIN=2, pwr_rdy=1, ce=1, inputs 100,200,300,400 on consecutive cycles -> pwr_vld pulses 1 cycle after the 4th sample with pwr_out=250; overrun=0.
- LOG2_WIN=2, four samples of 2**30-1 -> pwr_out=2**30-1, with no wrap in the accumulator (sum 0xFFFFFFFC).
- LOG2_WIN=2, pwr_rdy=0, 8 samples of value 8 then 8 samples of value 4 -> pwr_out stays 8, overrun=1 after the second window. Then pwr_rdy=1 -> pwr_vld drops the next cycle.
- LOG2_WIN=2, pwr_rdy=1, prod_vld valid every cycle, ce toggling 1/0 -> a result appears only after 4 ce-qualified samples. Inputs 1,2,3,6 -> pwr_out=3.
- LOG2_WIN=2: 2 samples, then clear with a concurrent sample, then samples 40,40,40,40 -> pwr_out=40. Clear also zeroes overrun.
- Assert reset asynchronously (between edges) after 3 samples -> all outputs 0 immediately. Then 4 samples of 12 -> pwr_out=12.
